// File: rtl/signed_sub_with_overflow_pipe_if.sv
// Operand (up) and result (down) valid/ready channels of the
// signed subtractor pipe.
interface signed_sub_with_overflow_pipe_if #(
    parameter int WIDTH = 4
);
    logic             up_valid;
    logic             up_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             down_valid;
    logic             down_ready;
    logic [WIDTH-1:0] diff;
    logic             overflow;

    modport master (
        output up_valid,
        output a,
        output b,
        output down_ready,
        input  up_ready,
        input  down_valid,
        input  diff,
        input  overflow
    );

    modport slave (
        input  up_valid,
        input  a,
        input  b,
        input  down_ready,
        output up_ready,
        output down_valid,
        output diff,
        output overflow
    );
endinterface

// File: rtl/signed_sub_with_overflow_pipe.sv
// Two-stage valid/ready signed subtractor with overflow flag
// and a saturating count of delivered overflowing results.
module signed_sub_with_overflow_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    signed_sub_with_overflow_pipe_if.slave bus,
    input  logic                           ovf_clear,
    output logic [CNT_W-1:0]               ovf_count
);
    localparam int MSB = WIDTH - 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             ovf;
    } s2_t;

    logic             s1_valid_q;
    logic             s1_valid_d;
    s1_t              s1_q;
    s1_t              s1_d;
    logic             s2_valid_q;
    logic             s2_valid_d;
    s2_t              s2_q;
    s2_t              s2_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             s1_adv;
    logic             s2_adv;
    logic             down_hs;
    logic [WIDTH-1:0] diff_w;
    logic             ovf_w;

    assign s2_adv  = ~s2_valid_q | bus.down_ready;
    assign s1_adv  = ~s1_valid_q | s2_adv;
    assign down_hs = s2_valid_q & bus.down_ready;

    // Overflow is only possible when the operand signs differ.
    assign diff_w = s1_q.a + ~s1_q.b + WIDTH'(1);
    assign ovf_w  = (s1_q.a[MSB] != s1_q.b[MSB])
                  & (diff_w[MSB] != s1_q.a[MSB]);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_adv) begin
            s1_valid_d = bus.up_valid;
            if (bus.up_valid) begin
                s1_d.a = bus.a;
                s1_d.b = bus.b;
            end
        end
    end

    // A bubble moving into S2 keeps the last result on the bus.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d.diff = diff_w;
                s2_d.ovf  = ovf_w;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (ovf_clear) begin
            cnt_d = '0;
        end else if (down_hs && s2_q.ovf
                     && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.up_ready   = s1_adv;
    assign bus.down_valid = s2_valid_q;
    assign bus.diff       = s2_q.diff;
    assign bus.overflow   = s2_q.ovf;
    assign ovf_count      = cnt_q;
endmodule

// File: tb/tb_signed_sub_with_overflow_pipe.sv
// Scoreboard bench for the signed subtractor pipe (WIDTH=4, CNT_W=2).
module tb_signed_sub_with_overflow_pipe;
    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ovf_clear = 1'b0;
    logic [CW-1:0] ovf_count;

    always #5 clk = ~clk;

    signed_sub_with_overflow_pipe_if #(.WIDTH(W)) bus ();

    signed_sub_with_overflow_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ovf_clear (ovf_clear),
        .ovf_count (ovf_count)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         o;
        int           acc;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            stepno = 0;
    int            delivered = 0;
    int            accepted = 0;
    int            dlv_before = 0;
    bit            chk_lat = 1'b0;
    logic          ur_s, dv_s, ovf_s, acc_s;
    logic [W-1:0]  diff_s;
    logic [CW-1:0] cnt_s, cnt_exp_s;
    logic [CW-1:0] cnt_m = '0;

    // One clock: drive at negedge, sample 1ns later, score the
    // handshakes that the coming posedge will perform.
    task automatic step(input logic uv, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic dr,
                        input logic clr);
        exp_t e;
        exp_t g;
        int   dd;
        logic gov;
        @(negedge clk);
        bus.up_valid   = uv;
        bus.a          = ia;
        bus.b          = ib;
        bus.down_ready = dr;
        ovf_clear      = clr;
        #1;
        stepno++;
        ur_s       = bus.up_ready;
        dv_s       = bus.down_valid;
        diff_s     = bus.diff;
        ovf_s      = bus.overflow;
        cnt_s      = ovf_count;
        cnt_exp_s  = cnt_m;
        acc_s      = uv && ur_s;
        dlv_before = delivered;
        gov        = 1'b0;
        if (dv_s === 1'b1 && dr) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result diff=%h ovf=%b with nothing pending",
                         diff_s, ovf_s);
            end else begin
                g   = sb.pop_front();
                gov = g.o;
                if (diff_s !== g.d || ovf_s !== g.o) begin
                    errors++;
                    $display("FAIL result diff/ovf got %h/%b expected %h/%b",
                             diff_s, ovf_s, g.d, g.o);
                end
                if (chk_lat) begin
                    checks++;
                    if (stepno != g.acc + 2) begin
                        errors++;
                        $display("FAIL latency got %0d cycles expected 2",
                                 stepno - g.acc);
                    end
                end
            end
            delivered++;
        end
        if (acc_s) begin
            dd   = int'($signed(ia)) - int'($signed(ib));
            e.d  = dd[W-1:0];
            e.o  = (dd < -(2 ** (W - 1))) || (dd > 2 ** (W - 1) - 1);
            e.acc = stepno;
            sb.push_back(e);
            accepted++;
        end
        if (clr) cnt_m = '0;
        else if (gov && cnt_m != {CW{1'b1}}) cnt_m = cnt_m + 1'b1;
    endtask

    task automatic test_reset;
        bus.up_valid   = 1'b1;
        bus.a          = 4'h7;
        bus.b          = 4'h8;
        bus.down_ready = 1'b1;
        ovf_clear      = 1'b0;
        rst_n          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (bus.down_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_down_valid got %b expected 0", bus.down_valid);
        end
        if (bus.diff !== '0) begin
            errors++;
            $display("FAIL reset_diff got %h expected 0", bus.diff);
        end
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow got %b expected 0", bus.overflow);
        end
        if (ovf_count !== '0) begin
            errors++;
            $display("FAIL reset_ovf_count got %0d expected 0", ovf_count);
        end
        if (bus.up_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_up_ready got %b expected 1", bus.up_ready);
        end
        bus.up_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [W-1:0] va[5];
        logic [W-1:0] vb[5];
        int           d0;
        va = '{4'd3, 4'd7, 4'h8, 4'h8, 4'd0};
        vb = '{4'd5, 4'hF, 4'd1, 4'h8, 4'h8};
        step(1'b0, '0, '0, 1'b1, 1'b1);
        chk_lat = 1'b1;
        d0 = delivered;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, va[i], vb[i], 1'b1, 1'b0);
            checks++;
            if (ur_s !== 1'b1) begin
                errors++;
                $display("FAIL basic_up_ready pair %0d got %b expected 1", i, ur_s);
            end
        end
        repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);
        checks += 2;
        if (delivered - d0 != 5 || sb.size() != 0) begin
            errors++;
            $display("FAIL basic_count delivered %0d pending %0d expected 5/0",
                     delivered - d0, sb.size());
        end
        if (cnt_s !== cnt_exp_s) begin
            errors++;
            $display("FAIL basic_ovf_count got %0d expected %0d", cnt_s, cnt_exp_s);
        end
        chk_lat = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [W-1:0] pa[4];
        logic [W-1:0] pb[4];
        logic [W-1:0] hd;
        logic         ho;
        int           n;
        int           c;
        pa = '{4'd2, 4'hD, 4'd5, 4'd1};
        pb = '{4'd5, 4'd6, 4'hC, 4'd1};
        n  = 0;
        hd = '0;
        ho = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(n < 4, pa[n & 3], pb[n & 3], 1'b0, 1'b0);
            if (acc_s) n++;
            if (k == 1) begin
                checks++;
                if (ur_s !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_second_ready got %b expected 1", ur_s);
                end
            end
            if (k == 2) begin
                checks += 2;
                if (ur_s !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_up_ready_drop got %b expected 0", ur_s);
                end
                if (dv_s !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_down_valid got %b expected 1", dv_s);
                end
                hd = diff_s;
                ho = ovf_s;
            end
            if (k > 2) begin
                checks++;
                if (diff_s !== hd || ovf_s !== ho || dv_s !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_stable got %h/%b/%b expected %h/%b/1",
                             diff_s, ovf_s, dv_s, hd, ho);
                end
            end
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL bp_accepted_while_stalled got %0d expected 2", n);
        end
        c = 0;
        while ((n < 4 || sb.size() != 0) && c < 20) begin
            step(n < 4, pa[n & 3], pb[n & 3], 1'b1, 1'b0);
            if (c == 0) begin
                checks++;
                if (ur_s !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_release_ready got %b expected 1", ur_s);
                end
            end
            if (acc_s) n++;
            c++;
        end
        checks++;
        if (n != 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL bp_drain accepted %0d pending %0d expected 4/0",
                     n, sb.size());
        end
    endtask

    task automatic test_counter_sat;
        logic [CW-1:0] seq[5];
        int            d0;
        int            last;
        int            k;
        seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        step(1'b0, '0, '0, 1'b1, 1'b1);
        d0   = delivered;
        last = 0;
        for (int i = 0; i < 9; i++) begin
            step(i < 5, 4'd7, 4'hF, 1'b1, 1'b0);
            k = dlv_before - d0;
            if (k >= 1 && k <= 5 && k != last) begin
                last = k;
                checks++;
                if (cnt_s !== seq[k-1]) begin
                    errors++;
                    $display("FAIL sat_count after %0d got %0d expected %0d",
                             k, cnt_s, seq[k-1]);
                end
            end
        end
        checks++;
        if (last != 5) begin
            errors++;
            $display("FAIL sat_deliveries got %0d expected 5", last);
        end
        step(1'b1, 4'h8, 4'd1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (dv_s !== 1'b1 || ovf_s !== 1'b1) begin
            errors++;
            $display("FAIL sat_sixth_pending got %b/%b expected 1/1", dv_s, ovf_s);
        end
        step(1'b0, '0, '0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (cnt_s !== 2'd0) begin
            errors++;
            $display("FAIL sat_clear_wins got %0d expected 0", cnt_s);
        end
    endtask

    task automatic test_random;
        int a0;
        int cyc;
        int target;
        step(1'b0, '0, '0, 1'b1, 1'b1);
        a0     = accepted;
        target = 10000;
        cyc    = 0;
        while (accepted - a0 < target && cyc < 60000) begin
            step($urandom_range(9) < 7, W'($urandom), W'($urandom),
                 $urandom_range(9) < 7, $urandom_range(63) == 0);
            checks++;
            if (cnt_s !== cnt_exp_s) begin
                errors++;
                $display("FAIL rand_ovf_count got %0d expected %0d",
                         cnt_s, cnt_exp_s);
            end
            cyc++;
        end
        checks++;
        if (accepted - a0 < target) begin
            errors++;
            $display("FAIL rand_timeout accepted %0d expected %0d",
                     accepted - a0, target);
        end
        repeat (4) step(1'b0, '0, '0, 1'b1, 1'b0);
        checks += 2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rand_drain pending %0d expected 0", sb.size());
        end
        if (cnt_s !== cnt_exp_s) begin
            errors++;
            $display("FAIL rand_final_count got %0d expected %0d",
                     cnt_s, cnt_exp_s);
        end
    endtask

    task automatic test_reset_midflight;
        step(1'b1, 4'd6, 4'd2, 1'b0, 1'b0);
        step(1'b1, 4'd7, 4'hE, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (dv_s !== 1'b1 || ur_s !== 1'b0) begin
            errors++;
            $display("FAIL mid_in_flight got dv=%b ur=%b expected 1/0", dv_s, ur_s);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.down_valid !== 1'b0 || bus.diff !== '0
            || bus.overflow !== 1'b0 || ovf_count !== '0
            || bus.up_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_values got dv=%b diff=%h ovf=%b cnt=%0d ur=%b",
                     bus.down_valid, bus.diff, bus.overflow, ovf_count,
                     bus.up_ready);
        end
        sb.delete();
        cnt_m = '0;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0);
            checks++;
            if (dv_s !== 1'b0) begin
                errors++;
                $display("FAIL mid_stale cycle %0d got dv=%b expected 0", i, dv_s);
            end
        end
        chk_lat = 1'b1;
        step(1'b1, 4'd3, 4'd5, 1'b1, 1'b0);
        repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);
        chk_lat = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL mid_after_release pending %0d expected 0", sb.size());
        end
    endtask

    initial begin
        bus.up_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.down_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_counter_sat();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/signed_sub_with_overflow_pipe.md
# signed_sub_with_overflow_pipe

Pipelined signed subtractor with overflow detection. It computes `a - b` on two's-complement operands and flags results that fall outside the signed range. Each stage has valid/ready flow control, and a saturating counter records overflow events. It is the subtraction counterpart of the signed adder-with-overflow and sits in the arithmetic datapath of the same section, between a valid/ready producer and consumer.

## Interface
- `WIDTH`, 4, operand/result width in bits, two's complement, ≥ 2
- `CNT_W`, 8, width of the overflow event counter
- `clk`  input  1  clock, all state on rising edge
- `rst_n`  input  1  reset, asynchronous, active-low
- `up_valid`  input  1  operand pair valid
- `up_ready`  output  1  block can accept operand pair this cycle
- `a`  input  WIDTH  minuend, signed
- `b`  input  WIDTH  subtrahend, signed
- `down_valid`  output  1  result valid
- `down_ready`  input  1  consumer accepts result this cycle
- `diff`  output  WIDTH  `(a - b) mod 2^WIDTH`
- `overflow`  output  1  true signed result not representable in WIDTH bits
- `ovf_clear`  input  1  synchronous clear of `ovf_count`
- `ovf_count`  output  CNT_W  number of delivered results with `overflow`=1, saturating

## Operation
- **Stage 1 (S1).** Registers `a`, `b` and a valid bit. Loads on the upstream handshake `up_valid & up_ready`.
- **Stage 2 (S2).** Registers `diff`, `overflow` and `down_valid`, all computed from the S1 operands.
- **Arithmetic.**
  - `diff = a + ~b + 1`, truncated to WIDTH bits, with no carry-out port.
  - `overflow = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB])`, using the S1 operands.
- **Flow control** (standard pipeline, no skid buffer):
  - `s2_adv = ~down_valid | down_ready`
  - `s1_adv = ~s1_valid | s2_adv`
  - `up_ready = s1_adv`, which is combinational. `up_ready` must not depend on `up_valid`.
  - S2 loads when `s2_adv`, with `down_valid <= s1_valid`. When S2 loads a bubble, `diff` and `overflow` hold their previous values.
  - S1 loads when `s1_adv`, with `s1_valid <= up_valid`.
- **Output stability.** While `down_valid=1` and `down_ready=0`, `diff`, `overflow` and `down_valid` hold their values.
- **Ordering.** Results are delivered in acceptance order, one per accepted pair. There is no drop or duplication.
- **Counter.**
  - On each downstream handshake with `overflow=1`, `ovf_count` increments by 1.
  - It holds at `2^CNT_W - 1` and never wraps.
  - `ovf_clear` sets `ovf_count` to 0. If a clear and an increment fall in the same cycle, the clear wins and the result is 0.

## Timing
- **Reset values.** While `rst_n` is low:
  - `down_valid`=0, `diff`=0, `overflow`=0, `ovf_count`=0.
  - S1 valid=0 and S1 operands=0.
  - Inputs are ignored.
  - `up_ready`=1, because the stages are empty.
- **Reset mid-operation.** Asserting reset discards all in-flight pairs immediately, without waiting for a clock edge. No partial result is delivered after reset is released.
- **Latency.** A pair accepted at edge N appears with `down_valid`=1 after edge N+1. With `down_ready` held high, it is consumed at edge N+2.
- **Throughput.** With `down_ready` held at 1, the block accepts one pair per cycle and there are no bubbles.
- **Backpressure.**
  - With `down_ready`=0, the pipeline fills two deep.
  - `up_ready` drops in the cycle where both stages are valid and `down_ready`=0.
  - When `down_ready` returns to 1, `up_ready`=1 in that same cycle.
- **Counter update.** `ovf_count` updates on the same edge as the downstream handshake that delivers the overflowing result.

## Test plan
- **Basic results** (WIDTH=4, back-to-back, `down_ready`=1). Expected `diff` and `overflow` values are listed after the arrow; all arrive in order, one per cycle, two cycles after acceptance.
  - 3−5 → 4'b1110, 0
  - 7−(−1) → 4'b1000, 1
  - −8−1 → 4'b0111, 1
  - −8−(−8) → 0, 0
  - 0−(−8) → 4'b1000, 1
- **Backpressure.** Send 4 pairs with `down_ready`=0 for 5 cycles.
  - `up_ready` falls after 2 pairs are accepted.
  - `diff`/`overflow` stay stable while stalled.
  - After `down_ready`=1, all 4 results arrive in order with no loss.
- **Counter saturation** (CNT_W=2). Deliver 5 overflowing results.
  - `ovf_count` sequence: 1, 2, 3, 3, 3.
  - Assert `ovf_clear` in the same cycle as a 6th overflow handshake → `ovf_count`=0.
- **Random stimulus.**
  - Random `up_valid`/`down_ready` over 10k pairs.
  - The scoreboard compares against a reference: `diff`=(a−b) mod 16, and `overflow` is set iff the integer a−b ∉ [−8,7].
  - The final `ovf_count` matches the scoreboard count.
- **Reset mid-flight.** With 2 pairs in flight, pulse `rst_n` low between clock edges.
  - `down_valid` goes to 0 immediately and all outputs go to their reset values.
  - No stale result appears after release.
  - The next accepted pair returns its correct result with a latency of 2.
